// File: rtl/psram_bist.sv
// Built-in self-test sequencer for the PSRAM controller. It writes a pattern over an
// address window, reads it back and verifies it, and reports the first failure.
module psram_bist #(
  parameter int AW    = 24,
  parameter int DW    = 16,
  parameter int TMO_W = 8
) (
  input  logic          clk_100mhz,
  input  logic          rstn_i,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic [1:0]    i_mode,
  input  logic          i_continuous,
  input  logic [AW-1:0] i_addr_first,
  input  logic [AW-1:0] i_addr_last,
  input  logic [DW-1:0] i_seed,
  output logic          o_stb,
  output logic          o_we,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_din,
  input  logic          i_busy,
  input  logic [DW-1:0] i_dout,
  output logic          o_running,
  output logic          o_finished,
  output logic          o_success,
  output logic          o_timeout,
  output logic [AW-1:0] o_fail_addr,
  output logic [DW-1:0] o_fail_actual,
  output logic [DW-1:0] o_fail_expect,
  output logic [15:0]   o_pass_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_REQ, S_WR_ACK, S_WR_WAIT,
    S_RD_REQ, S_RD_ACK, S_RD_WAIT, S_CHECK, S_DONE
  } state_t;

  // The handshake counter reaches this value on the last allowed wait cycle.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((1 << TMO_W) - 2);
  localparam logic [DW-1:0]    DW_L     = DW'(DW);

  function automatic logic [DW-1:0] pattern(input logic [1:0]    mode,
                                            input logic [AW-1:0] addr,
                                            input logic [DW-1:0] seed);
    logic [DW-1:0] a;
    logic [DW-1:0] sum;
    a   = DW'(addr);
    sum = a + seed;
    unique case (mode)
      2'd0:    pattern = seed;
      2'd1:    pattern = a ^ seed;
      2'd2:    pattern = DW'(1) << (sum % DW_L);
      default: pattern = ~(a ^ seed);
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic            cont_q, cont_d;
  logic [AW-1:0]   first_q, first_d;
  logic [AW-1:0]   last_q, last_d;
  logic [DW-1:0]   seed_q, seed_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   din_q, din_d;
  logic            stb_q, stb_d;
  logic            we_q, we_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic            running_q, running_d;
  logic            finished_q, finished_d;
  logic            success_q, success_d;
  logic            timeout_q, timeout_d;
  logic [AW-1:0]   fail_addr_q, fail_addr_d;
  logic [DW-1:0]   fail_actual_q, fail_actual_d;
  logic [DW-1:0]   fail_expect_q, fail_expect_d;
  logic [15:0]     pass_cnt_q, pass_cnt_d;

  logic [DW-1:0]   cur_pat;
  logic            wait_done;

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a latch.
    state_d       = state_q;
    mode_d        = mode_q;
    cont_d        = cont_q;
    first_d       = first_q;
    last_d        = last_q;
    seed_d        = seed_q;
    addr_d        = addr_q;
    din_d         = din_q;
    stb_d         = stb_q;
    we_d          = we_q;
    tmo_d         = tmo_q;
    running_d     = running_q;
    finished_d    = finished_q;
    success_d     = success_q;
    timeout_d     = timeout_q;
    fail_addr_d   = fail_addr_q;
    fail_actual_d = fail_actual_q;
    fail_expect_d = fail_expect_q;
    pass_cnt_d    = pass_cnt_q;
    cur_pat       = pattern(mode_q, addr_q, seed_q);
    wait_done     = 1'b0;

    if (state_q != S_IDLE && i_abort) begin
      state_d    = S_IDLE;
      stb_d      = 1'b0;
      we_d       = 1'b0;
      running_d  = 1'b0;
      finished_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            mode_d        = i_mode;
            cont_d        = i_continuous;
            first_d       = i_addr_first;
            last_d        = i_addr_last;
            seed_d        = i_seed;
            addr_d        = i_addr_first;
            finished_d    = 1'b0;
            success_d     = 1'b0;
            timeout_d     = 1'b0;
            fail_addr_d   = '0;
            fail_actual_d = '0;
            fail_expect_d = '0;
            pass_cnt_d    = '0;
            if (i_addr_last < i_addr_first) begin
              // Empty window: report failure without touching memory.
              state_d     = S_DONE;
              finished_d  = 1'b1;
              fail_addr_d = i_addr_first;
            end else begin
              state_d   = S_WR_REQ;
              running_d = 1'b1;
            end
          end
        end
        S_WR_REQ: begin
          stb_d   = 1'b1;
          we_d    = 1'b1;
          din_d   = cur_pat;
          tmo_d   = '0;
          state_d = S_WR_ACK;
        end
        S_RD_REQ: begin
          stb_d   = 1'b1;
          we_d    = 1'b0;
          tmo_d   = '0;
          state_d = S_RD_ACK;
        end
        S_WR_ACK, S_WR_WAIT, S_RD_ACK, S_RD_WAIT: begin
          wait_done = (state_q == S_WR_ACK || state_q == S_RD_ACK) ? i_busy : !i_busy;
          if (wait_done) begin
            tmo_d = '0;
            unique case (state_q)
              S_WR_ACK: begin
                stb_d   = 1'b0;
                we_d    = 1'b0;
                state_d = S_WR_WAIT;
              end
              S_RD_ACK: begin
                stb_d   = 1'b0;
                state_d = S_RD_WAIT;
              end
              S_WR_WAIT: begin
                if (addr_q == last_q) begin
                  addr_d  = first_q;
                  state_d = S_RD_REQ;
                end else begin
                  addr_d  = addr_q + 1'b1;
                  state_d = S_WR_REQ;
                end
              end
              default: state_d = S_CHECK;
            endcase
          end else if (tmo_q == TMO_LAST) begin
            stb_d       = 1'b0;
            we_d        = 1'b0;
            timeout_d   = 1'b1;
            success_d   = 1'b0;
            fail_addr_d = addr_q;
            finished_d  = 1'b1;
            running_d   = 1'b0;
            state_d     = S_DONE;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        S_CHECK: begin
          if (i_dout != cur_pat) begin
            fail_addr_d   = addr_q;
            fail_actual_d = i_dout;
            fail_expect_d = cur_pat;
            success_d     = 1'b0;
            finished_d    = 1'b1;
            running_d     = 1'b0;
            state_d       = S_DONE;
          end else if (addr_q != last_q) begin
            addr_d  = addr_q + 1'b1;
            state_d = S_RD_REQ;
          end else begin
            if (pass_cnt_q != 16'hFFFF) pass_cnt_d = pass_cnt_q + 1'b1;
            if (cont_q) begin
              seed_d  = seed_q + 1'b1;
              addr_d  = first_q;
              state_d = S_WR_REQ;
            end else begin
              success_d  = 1'b1;
              finished_d = 1'b1;
              running_d  = 1'b0;
              state_d    = S_DONE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= S_IDLE;
      mode_q        <= '0;
      cont_q        <= 1'b0;
      first_q       <= '0;
      last_q        <= '0;
      seed_q        <= '0;
      addr_q        <= '0;
      din_q         <= '0;
      stb_q         <= 1'b0;
      we_q          <= 1'b0;
      tmo_q         <= '0;
      running_q     <= 1'b0;
      finished_q    <= 1'b0;
      success_q     <= 1'b0;
      timeout_q     <= 1'b0;
      fail_addr_q   <= '0;
      fail_actual_q <= '0;
      fail_expect_q <= '0;
      pass_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      cont_q        <= cont_d;
      first_q       <= first_d;
      last_q        <= last_d;
      seed_q        <= seed_d;
      addr_q        <= addr_d;
      din_q         <= din_d;
      stb_q         <= stb_d;
      we_q          <= we_d;
      tmo_q         <= tmo_d;
      running_q     <= running_d;
      finished_q    <= finished_d;
      success_q     <= success_d;
      timeout_q     <= timeout_d;
      fail_addr_q   <= fail_addr_d;
      fail_actual_q <= fail_actual_d;
      fail_expect_q <= fail_expect_d;
      pass_cnt_q    <= pass_cnt_d;
    end
  end

  assign o_stb         = stb_q;
  assign o_we          = we_q;
  assign o_addr        = addr_q;
  assign o_din         = din_q;
  assign o_running     = running_q;
  assign o_finished    = finished_q;
  assign o_success     = success_q;
  assign o_timeout     = timeout_q;
  assign o_fail_addr   = fail_addr_q;
  assign o_fail_actual = fail_actual_q;
  assign o_fail_expect = fail_expect_q;
  assign o_pass_count  = pass_cnt_q;

endmodule

// File: tb/tb_psram_bist.sv
// Directed bench for psram_bist: a 3-cycle-busy controller model with sparse memory,
// read corruption and a "never busy" mode, driven through hand-computed scenarios.
module tb_psram_bist;

  logic        clk_100mhz = 1'b0;
  logic        rstn_i     = 1'b0;
  logic        i_start    = 1'b0;
  logic        i_abort    = 1'b0;
  logic [1:0]  i_mode     = '0;
  logic        i_continuous = 1'b0;
  logic [23:0] i_addr_first = '0;
  logic [23:0] i_addr_last  = '0;
  logic [15:0] i_seed     = '0;
  logic        o_stb, o_we;
  logic [23:0] o_addr;
  logic [15:0] o_din;
  logic        i_busy = 1'b0;
  logic [15:0] i_dout = '0;
  logic        o_running, o_finished, o_success, o_timeout;
  logic [23:0] o_fail_addr;
  logic [15:0] o_fail_actual, o_fail_expect, o_pass_count;

  psram_bist #(.AW(24), .DW(16), .TMO_W(4)) dut (
    .clk_100mhz    (clk_100mhz),
    .rstn_i        (rstn_i),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_mode        (i_mode),
    .i_continuous  (i_continuous),
    .i_addr_first  (i_addr_first),
    .i_addr_last   (i_addr_last),
    .i_seed        (i_seed),
    .o_stb         (o_stb),
    .o_we          (o_we),
    .o_addr        (o_addr),
    .o_din         (o_din),
    .i_busy        (i_busy),
    .i_dout        (i_dout),
    .o_running     (o_running),
    .o_finished    (o_finished),
    .o_success     (o_success),
    .o_timeout     (o_timeout),
    .o_fail_addr   (o_fail_addr),
    .o_fail_actual (o_fail_actual),
    .o_fail_expect (o_fail_expect),
    .o_pass_count  (o_pass_count)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Controller model state
  logic [15:0] mem [logic [23:0]];
  int          busy_cnt    = 0;
  bit          model_en    = 1'b1;
  bit          corrupt_en  = 1'b0;
  logic [23:0] corrupt_addr = '0;
  logic [23:0] win_lo = '0, win_hi = '0;
  int          wr_cnt = 0, rd_cnt = 0, stray_cnt = 0;
  int          test_id = 0;

  always @(negedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      i_busy   = 1'b0;
      busy_cnt = 0;
    end else if (busy_cnt != 0) begin
      busy_cnt--;
      if (busy_cnt == 0) i_busy = 1'b0;
    end else if (model_en && o_stb) begin
      i_busy   = 1'b1;
      busy_cnt = 3;
      if (o_addr < win_lo || o_addr > win_hi) stray_cnt++;
      if (o_we) begin
        if (test_id == 4)
          check("t4_walk_data", o_din, 16'h1 << ((o_addr[3:0] + wr_cnt / 16) % 16));
        mem[o_addr] = o_din;
        wr_cnt++;
      end else begin
        i_dout = mem.exists(o_addr) ? mem[o_addr] : 16'h0000;
        if (corrupt_en && o_addr == corrupt_addr) i_dout = i_dout ^ 16'h0008;
        rd_cnt++;
      end
    end
  end

  task automatic clear_log(input int id, input logic [23:0] lo, input logic [23:0] hi);
    test_id   = id;
    wr_cnt    = 0;
    rd_cnt    = 0;
    stray_cnt = 0;
    win_lo    = lo;
    win_hi    = hi;
    mem.delete();
  endtask

  // Start pulse, then scramble the inputs to show they were latched.
  task automatic start_test(input logic [1:0] mode, input logic cont,
                            input logic [23:0] first, input logic [23:0] last,
                            input logic [15:0] seed);
    @(negedge clk_100mhz);
    i_mode = mode; i_continuous = cont; i_addr_first = first; i_addr_last = last;
    i_seed = seed; i_start = 1'b1;
    @(negedge clk_100mhz);
    i_start = 1'b0;
    i_mode = ~mode; i_continuous = ~cont; i_addr_first = last; i_addr_last = first;
    i_seed = ~seed;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    i = 0;
    while (!o_finished && i < budget) begin
      @(negedge clk_100mhz);
      i++;
    end
    check({tag, "_finished"}, o_finished, 1);
  endtask

  function automatic logic any_out();
    return |{o_stb, o_we, o_addr, o_din, o_running, o_finished, o_success, o_timeout,
             o_fail_addr, o_fail_actual, o_fail_expect, o_pass_count};
  endfunction

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stb_cycles;
    int i;

    repeat (3) @(negedge clk_100mhz);
    check("reset_outputs_zero", any_out(), 0);
    rstn_i = 1'b1;
    @(negedge clk_100mhz);
    check("idle_outputs_zero", any_out(), 0);

    // 1: mode1 seed 00FF window 0..7 single-shot
    clear_log(1, 24'd0, 24'd7);
    start_test(2'd1, 1'b0, 24'd0, 24'd7, 16'h00FF);
    check("t1_running", o_running, 1);
    wait_done("t1", 400);
    check("t1_success", o_success, 1);
    check("t1_timeout", o_timeout, 0);
    check("t1_pass_count", o_pass_count, 1);
    check("t1_running_off", o_running, 0);
    check("t1_writes", wr_cnt, 8);
    check("t1_reads", rd_cnt, 8);
    check("t1_stray", stray_cnt, 0);
    for (int a = 0; a < 8; a++)
      check("t1_mem", mem.exists(24'(a)) ? mem[24'(a)] : 16'hDEAD, 16'h00FF ^ 16'(a));

    // 2: mode0 seed A5A5, read at addr 5 corrupted on bit 3
    clear_log(2, 24'd0, 24'd7);
    corrupt_en = 1'b1;
    corrupt_addr = 24'd5;
    start_test(2'd0, 1'b0, 24'd0, 24'd7, 16'hA5A5);
    check("t2_restart_clears", o_finished, 0);
    wait_done("t2", 400);
    check("t2_success", o_success, 0);
    check("t2_timeout", o_timeout, 0);
    check("t2_fail_addr", o_fail_addr, 24'd5);
    check("t2_fail_expect", o_fail_expect, 16'hA5A5);
    check("t2_fail_actual", o_fail_actual, 16'hA5AD);
    check("t2_pass_count", o_pass_count, 0);
    repeat (10) @(negedge clk_100mhz);
    check("t2_writes", wr_cnt, 8);
    check("t2_reads_stop_at_5", rd_cnt, 6);
    corrupt_en = 1'b0;

    // 3: controller never busy -> timeout after 15 cycles of stb
    clear_log(3, 24'd3, 24'd9);
    model_en = 1'b0;
    start_test(2'd0, 1'b0, 24'd3, 24'd9, 16'h0000);
    stb_cycles = 0;
    i = 0;
    while (!o_finished && i < 60) begin
      @(negedge clk_100mhz);
      if (o_stb) stb_cycles++;
      i++;
    end
    check("t3_finished", o_finished, 1);
    check("t3_stb_cycles", stb_cycles, 15);
    check("t3_timeout", o_timeout, 1);
    check("t3_success", o_success, 0);
    check("t3_fail_addr", o_fail_addr, 24'd3);
    check("t3_stb_low", o_stb, 0);
    model_en = 1'b1;

    // 4: continuous walking-one window 0..15, abort after 3 passes
    clear_log(4, 24'd0, 24'd15);
    start_test(2'd2, 1'b1, 24'd0, 24'd15, 16'h0000);
    i = 0;
    while (o_pass_count < 16'd3 && !o_finished && i < 3000) begin
      @(negedge clk_100mhz);
      i++;
    end
    check("t4_pass_count", o_pass_count, 3);
    check("t4_not_finished", o_finished, 0);
    check("t4_running", o_running, 1);
    check("t4_writes", wr_cnt, 48);
    check("t4_reads", rd_cnt, 48);
    i_abort = 1'b1;
    @(negedge clk_100mhz);
    i_abort = 1'b0;
    check("t4_abort_stb", o_stb, 0);
    check("t4_abort_running", o_running, 0);
    check("t4_abort_finished", o_finished, 0);
    repeat (6) @(negedge clk_100mhz);
    check("t4_idle_no_writes", wr_cnt, 48);

    // 5: inverted window finishes at once with no access
    clear_log(5, 24'd4, 24'd10);
    start_test(2'd0, 1'b0, 24'd10, 24'd4, 16'h0000);
    check("t5_finished_next", o_finished, 1);
    check("t5_success", o_success, 0);
    check("t5_timeout", o_timeout, 0);
    check("t5_fail_addr", o_fail_addr, 24'd10);
    stb_cycles = 0;
    for (int k = 0; k < 5; k++) begin
      if (o_stb) stb_cycles++;
      @(negedge clk_100mhz);
    end
    check("t5_no_stb", stb_cycles, 0);

    // 5b: asynchronous reset in the middle of a write
    clear_log(5, 24'd0, 24'd7);
    start_test(2'd1, 1'b0, 24'd0, 24'd7, 16'h0000);
    i = 0;
    while (!(wr_cnt >= 2 && o_stb && o_we) && i < 200) begin
      @(negedge clk_100mhz);
      i++;
    end
    check("t5_mid_write_reached", o_stb & o_we, 1);
    #2 rstn_i = 1'b0;
    #1 check("t5_async_reset", any_out(), 0);
    @(negedge clk_100mhz);
    rstn_i = 1'b1;
    @(negedge clk_100mhz);
    check("t5_after_reset", any_out(), 0);

    // 6: window at the very top of the address space
    clear_log(6, 24'hFFFFFE, 24'hFFFFFF);
    start_test(2'd1, 1'b0, 24'hFFFFFE, 24'hFFFFFF, 16'h1234);
    wait_done("t6", 200);
    check("t6_success", o_success, 1);
    check("t6_pass_count", o_pass_count, 1);
    check("t6_writes", wr_cnt, 2);
    check("t6_reads", rd_cnt, 2);
    check("t6_no_wrap", stray_cnt, 0);
    check("t6_mem_lo", mem.exists(24'hFFFFFE) ? mem[24'hFFFFFE] : 16'hDEAD, 16'hEDCA);
    check("t6_mem_hi", mem.exists(24'hFFFFFF) ? mem[24'hFFFFFF] : 16'hDEAD, 16'hEDCB);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
